// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with valid/ready configuration, match pulse and auto-stop.
// Optional match counter / target / done logic is built when SEQCTL_MATCH_CNT_EN is defined.
module seq_det_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LEN_W  = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_target,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  input  logic              din,
  input  logic              din_valid,
  output logic              busy,
  output logic              match,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t            state;
  logic [MAXLEN-1:0] pat;
  logic [MAXLEN-1:0] hist;
  logic [MAXLEN-1:0] hist_nxt;
  logic [MAXLEN-1:0] mask;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  fill;
  logic [LEN_W-1:0]  fill_inc;
  logic              ovl;
  logic              loaded;
  logic              cfg_ok;
  logic              fill_ok;
  logic              hit;
  logic              match_q;
  logic              cfg_err_q;
  logic              unused_hist;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == ARMED);
  assign match     = match_q;
  assign cfg_err   = cfg_err_q;

  // Oldest history bit shifts out before it can take part in a compare
  assign unused_hist = hist[MAXLEN-1];

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAXLEN));
  assign hist_nxt = {hist[MAXLEN-2:0], din};
  assign fill_inc = (fill == LEN_W'(MAXLEN)) ? fill : fill + LEN_W'(1);
  assign fill_ok  = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);

  // Only the low len bits of the pattern participate in the compare
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = fill_ok && (((hist_nxt ^ pat) & mask) == '0);

`ifdef SEQCTL_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] tgt;
  logic             tgt_hit;
  logic             done_q;

  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign tgt_hit   = (tgt != '0) && (cnt_inc == tgt);
  assign match_cnt = cnt;
  assign done      = done_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^cfg_target;
  assign match_cnt  = '0;
  assign done       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      loaded    <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SEQCTL_MATCH_CNT_EN
      tgt       <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
`endif
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SEQCTL_MATCH_CNT_EN
      done_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              pat    <= cfg_pattern;
              len    <= cfg_len;
              ovl    <= cfg_overlap;
              loaded <= 1'b1;
`ifdef SEQCTL_MATCH_CNT_EN
              tgt    <= cfg_target;
`endif
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          // start sees loaded as it was before any same-cycle handshake
          if (start && loaded) begin
            state <= ARMED;
            hist  <= '0;
            fill  <= '0;
`ifdef SEQCTL_MATCH_CNT_EN
            cnt   <= '0;
`endif
          end
        end
        ARMED: begin
          if (stop) begin
            state <= IDLE;
          end else if (din_valid) begin
            hist <= hist_nxt;
            fill <= fill_inc;
            if (hit) begin
              match_q <= 1'b1;
              if (!ovl) begin
                fill <= '0;
              end
`ifdef SEQCTL_MATCH_CNT_EN
              cnt <= cnt_inc;
              if (tgt_hit) begin
                done_q <= 1'b1;
                state  <= IDLE;
              end
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
